// File: rtl/rv_mem_pkg.sv
// Shared types and helpers for the simulation memory.
// Response bundle and address range check.
package rv_mem_pkg;

  localparam int XLEN    = 32;
  localparam int WSTRB_W = XLEN / 8;

  typedef struct packed {
    logic            valid;
    logic            fault;
    logic [XLEN-1:0] data;
  } resp_t;

  // Limit is formed in 33 bits so base+size never wraps to a small value.
  function automatic logic addr_ok(
    input logic [XLEN-1:0] addr,
    input logic [XLEN-1:0] base,
    input int unsigned     depth
  );
    logic [XLEN:0] lim;
    lim = {1'b0, base} + ((XLEN+1)'(depth) << 2);
    return (addr[1:0] == 2'b00) &&
           (addr >= base) &&
           ({1'b0, addr} < lim);
  endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-latency response delay line.
// Final stage keeps its data between responses.
module mem_resp_pipe
  import rv_mem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  resp_t req,
  output resp_t rsp
);

  resp_t stg [LATENCY];
  resp_t src [LATENCY];

  assign src[0] = req;

  for (genvar g = 1; g < LATENCY; g++) begin : g_src
    assign src[g] = stg[g-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        stg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LATENCY - 1; i++) begin
        stg[i] <= src[i];
      end
      stg[LATENCY-1].valid <= src[LATENCY-1].valid;
      stg[LATENCY-1].fault <= src[LATENCY-1].fault;
      if (src[LATENCY-1].valid) begin
        stg[LATENCY-1].data <= src[LATENCY-1].data;
      end
    end
  end

  assign rsp = stg[LATENCY-1];

endmodule

// File: rtl/rv_sim_mem.sv
// Dual-port word memory for core benches: fetch port
// plus load/store port with strobes, latency and faults.
module rv_sim_mem
  import rv_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LATENCY     = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_valid,
  input  logic [XLEN-1:0]    fetch_addr,
  output logic [XLEN-1:0]    fetch_data,
  output logic               fetch_resp_valid,
  output logic               fetch_fault,
  input  logic               mem_read_valid,
  input  logic               mem_write_valid,
  input  logic [XLEN-1:0]    mem_addr,
  input  logic [XLEN-1:0]    mem_write_data,
  input  logic [WSTRB_W-1:0] mem_wstrb,
  output logic [XLEN-1:0]    mem_read_data,
  output logic               mem_resp_valid,
  output logic               mem_fault
);

  localparam int AW = $clog2(DEPTH_WORDS);

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_lat
    $error("rv_sim_mem: LATENCY %0d outside 1..4", LATENCY);
  end

  if ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("rv_sim_mem: DEPTH_WORDS %0d not a power of two",
           DEPTH_WORDS);
  end

  logic [XLEN-1:0] mem [DEPTH_WORDS];

  logic          f_ok;
  logic          d_ok;
  logic          d_acc;
  logic          do_wr;
  logic [AW-1:0] f_idx;
  logic [AW-1:0] d_idx;
  resp_t         f_req;
  resp_t         d_req;
  resp_t         f_rsp;
  resp_t         d_rsp;

  assign f_ok  = addr_ok(fetch_addr, BASE_ADDR, DEPTH_WORDS);
  assign d_ok  = addr_ok(mem_addr, BASE_ADDR, DEPTH_WORDS) &&
                 !(mem_read_valid && mem_write_valid);
  assign d_acc = mem_read_valid || mem_write_valid;
  assign do_wr = mem_write_valid && d_ok && !rst;

  assign f_idx = AW'((fetch_addr - BASE_ADDR) >> 2);
  assign d_idx = AW'((mem_addr - BASE_ADDR) >> 2);

  // Array is read combinationally here, so a same-edge store
  // is not visible to this request (read-before-write).
  always_comb begin
    f_req       = '0;
    f_req.valid = fetch_valid;
    f_req.fault = fetch_valid && !f_ok;
    if (fetch_valid && f_ok) begin
      f_req.data = mem[f_idx];
    end
  end

  always_comb begin
    d_req       = '0;
    d_req.valid = d_acc;
    d_req.fault = d_acc && !d_ok;
    if (mem_read_valid && d_ok) begin
      d_req.data = mem[d_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      for (int i = 0; i < WSTRB_W; i++) begin
        if (mem_wstrb[i]) begin
          mem[d_idx][8*i +: 8] <= mem_write_data[8*i +: 8];
        end
      end
    end
  end

  mem_resp_pipe #(
    .LATENCY(LATENCY)
  ) u_fetch_pipe (
    .clk(clk),
    .rst(rst),
    .req(f_req),
    .rsp(f_rsp)
  );

  mem_resp_pipe #(
    .LATENCY(LATENCY)
  ) u_data_pipe (
    .clk(clk),
    .rst(rst),
    .req(d_req),
    .rsp(d_rsp)
  );

  assign fetch_data       = f_rsp.data;
  assign fetch_resp_valid = f_rsp.valid;
  assign fetch_fault      = f_rsp.fault;
  assign mem_read_data    = d_rsp.data;
  assign mem_resp_valid   = d_rsp.valid;
  assign mem_fault        = d_rsp.fault;

endmodule

// File: tb/tb_rv_sim_mem.sv
// Bench for rv_sim_mem: four instances (LATENCY 1..4) share
// stimulus; responses are compared with a word-array model.
module tb_rv_sim_mem;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0;
  localparam int          NL    = 4;

  typedef struct packed {
    logic [31:0] cyc;
    logic        port;
    logic        fault;
    logic [31:0] data;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        fv;
  logic [31:0] fa;
  logic        mr;
  logic        mw;
  logic [31:0] ma;
  logic [31:0] wd;
  logic [3:0]  ws;

  logic [31:0] fdat [NL];
  logic        frv  [NL];
  logic        fflt [NL];
  logic [31:0] mdat [NL];
  logic        mrv  [NL];
  logic        mflt [NL];

  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  rec_t aq [NL][$];
  rec_t eq [NL][$];
  logic [31:0] mm [DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NL; g++) begin : g_dut
    rv_sim_mem #(
      .DEPTH_WORDS(DEPTH),
      .BASE_ADDR(BASE),
      .LATENCY(g + 1),
      .INIT_FILE("")
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .fetch_valid(fv),
      .fetch_addr(fa),
      .fetch_data(fdat[g]),
      .fetch_resp_valid(frv[g]),
      .fetch_fault(fflt[g]),
      .mem_read_valid(mr),
      .mem_write_valid(mw),
      .mem_addr(ma),
      .mem_write_data(wd),
      .mem_wstrb(ws),
      .mem_read_data(mdat[g]),
      .mem_resp_valid(mrv[g]),
      .mem_fault(mflt[g])
    );
  end

  always @(negedge clk) begin
    for (int g = 0; g < NL; g++) begin
      if (frv[g] === 1'b1)
        aq[g].push_back(rec_t'{32'(cyc), 1'b0, fflt[g], fdat[g]});
      if (mrv[g] === 1'b1)
        aq[g].push_back(rec_t'{32'(cyc), 1'b1, mflt[g], mdat[g]});
    end
  end

  // One cycle of stimulus; the model predicts each port's answer
  // and the cycle it must appear in for every latency.
  task automatic step(
    input logic        r,
    input logic        f_v,
    input logic [31:0] f_a,
    input logic        m_r,
    input logic        m_w,
    input logic [31:0] m_a,
    input logic [31:0] w_d,
    input logic [3:0]  w_s
  );
    longint lo, hi, fl, ml;
    bit fok, mok;
    logic [31:0] fd, md;
    int fi, mi;
    rst = r; fv = f_v; fa = f_a; mr = m_r;
    mw = m_w; ma = m_a; wd = w_d; ws = w_s;
    lo = longint'({32'd0, BASE});
    hi = lo + DEPTH * 4;
    fl = longint'({32'd0, f_a});
    ml = longint'({32'd0, m_a});
    if (r) begin
      for (int g = 0; g < NL; g++) begin
        rec_t keep[$];
        keep = {};
        for (int k = 0; k < eq[g].size(); k++)
          if (int'(eq[g][k].cyc) <= cyc) keep.push_back(eq[g][k]);
        eq[g] = keep;
      end
    end else begin
      fok = (fl % 4 == 0) && fl >= lo && fl < hi;
      mok = (ml % 4 == 0) && ml >= lo && ml < hi && !(m_r && m_w);
      fi = int'((fl - lo) / 4);
      mi = int'((ml - lo) / 4);
      fd = 32'h0;
      md = 32'h0;
      if (fok) fd = mm[fi];
      if (m_r && mok) md = mm[mi];
      for (int g = 0; g < NL; g++) begin
        if (f_v)
          eq[g].push_back(rec_t'{32'(cyc + g + 1), 1'b0, ~fok, fd});
        if (m_r || m_w)
          eq[g].push_back(rec_t'{32'(cyc + g + 1), 1'b1, ~mok, md});
      end
      if (m_w && mok)
        for (int b = 0; b < 4; b++)
          if (w_s[b]) mm[mi][8*b +: 8] = w_d[8*b +: 8];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    repeat (6) idle();
  endtask

  task automatic clear_logs();
    for (int g = 0; g < NL; g++) begin
      aq[g].delete();
      eq[g].delete();
    end
  endtask

  task automatic preload();
    for (int w = 0; w < DEPTH; w++)
      step(0, 0, 0, 0, 1, BASE + 32'(w * 4), $urandom, 4'hf);
    step(0, 0, 0, 0, 1, 32'h0, 32'h000000b3, 4'hf);
    step(0, 0, 0, 0, 1, 32'h4, 32'h00100113, 4'hf);
    step(0, 0, 0, 0, 1, 32'h8, 32'h00a00213, 4'hf);
    step(0, 0, 0, 0, 1, 32'h10, 32'h002000b3, 4'hf);
    drain();
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int g = 0; g < NL; g++) begin
      total++;
      if ({fdat[g], frv[g], fflt[g], mdat[g], mrv[g], mflt[g]}
          !== 70'd0) begin
        bad++;
        $display("FAIL reset L%0d outputs got %h %b%b %h %b%b want 0",
                 g + 1, fdat[g], frv[g], fflt[g],
                 mdat[g], mrv[g], mflt[g]);
      end
    end
  endtask

  task automatic test_fetch_seq();
    int t0;
    logic [31:0] prog [3];
    prog = '{32'h000000b3, 32'h00100113, 32'h00a00213};
    clear_logs();
    t0 = cyc;
    step(0, 1, 32'h0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h4, 0, 0, 0, 0, 0);
    step(0, 1, 32'h8, 0, 0, 0, 0, 0);
    drain();
    for (int g = 0; g < NL; g++) begin
      total++;
      if (aq[g].size() != eq[g].size()) begin
        bad++;
        $display("FAIL fetch_seq L%0d count got %0d want %0d",
                 g + 1, aq[g].size(), eq[g].size());
      end else for (int k = 0; k < eq[g].size(); k++) begin
        total++;
        if (aq[g][k] !== eq[g][k]) begin
          bad++;
          $display("FAIL fetch_seq L%0d #%0d got %h want %h",
                   g + 1, k, aq[g][k], eq[g][k]);
        end
      end
    end
    total++;
    if (aq[0].size() != 3) begin
      bad++;
      $display("FAIL fetch_seq_l1 count got %0d want 3", aq[0].size());
    end else for (int k = 0; k < 3; k++) begin
      total++;
      if (aq[0][k] !== rec_t'{32'(t0 + 1 + k), 1'b0, 1'b0, prog[k]}) begin
        bad++;
        $display("FAIL fetch_seq_l1 #%0d got %h want data %h cyc %0d",
                 k, aq[0][k], prog[k], t0 + 1 + k);
      end
    end
    total++;
    if ({fdat[0], frv[0], fflt[0]} !== {prog[2], 2'b00}) begin
      bad++;
      $display("FAIL fetch_hold got %h %b%b want %h 00",
               fdat[0], frv[0], fflt[0], prog[2]);
    end
  endtask

  task automatic test_store_load();
    int t0;
    clear_logs();
    t0 = cyc;
    step(0, 0, 0, 0, 1, 32'h40, 32'hDEADBEEF, 4'b1111);
    step(0, 0, 0, 1, 0, 32'h40, 0, 0);
    step(0, 0, 0, 0, 1, 32'h40, 32'h000000AA, 4'b0001);
    step(0, 0, 0, 1, 0, 32'h40, 0, 0);
    drain();
    for (int g = 0; g < NL; g++) begin
      total++;
      if (aq[g].size() != eq[g].size()) begin
        bad++;
        $display("FAIL store_load L%0d count got %0d want %0d",
                 g + 1, aq[g].size(), eq[g].size());
      end else for (int k = 0; k < eq[g].size(); k++) begin
        total++;
        if (aq[g][k] !== eq[g][k]) begin
          bad++;
          $display("FAIL store_load L%0d #%0d got %h want %h",
                   g + 1, k, aq[g][k], eq[g][k]);
        end
      end
    end
    total++;
    if (aq[2].size() != 4) begin
      bad++;
      $display("FAIL store_load_l3 count got %0d want 4", aq[2].size());
    end else begin
      total += 3;
      if (aq[2][0] !== rec_t'{32'(t0 + 3), 1'b1, 1'b0, 32'h0}) begin
        bad++;
        $display("FAIL store_resp_l3 got %h want cyc %0d data 0",
                 aq[2][0], t0 + 3);
      end
      if (aq[2][1] !== rec_t'{32'(t0 + 4), 1'b1, 1'b0, 32'hDEADBEEF}) begin
        bad++;
        $display("FAIL load_full_l3 got %h want cyc %0d DEADBEEF",
                 aq[2][1], t0 + 4);
      end
      if (aq[2][3] !== rec_t'{32'(t0 + 6), 1'b1, 1'b0, 32'hDEADBEAA}) begin
        bad++;
        $display("FAIL load_byte_l3 got %h want cyc %0d DEADBEAA",
                 aq[2][3], t0 + 6);
      end
    end
  endtask

  task automatic test_faults();
    int t0;
    clear_logs();
    t0 = cyc;
    step(0, 0, 0, 1, 0, 32'h42, 0, 0);
    step(0, 0, 0, 1, 0, BASE + DEPTH * 4, 0, 0);
    step(0, 0, 0, 1, 1, 32'h40, 32'h11111111, 4'hf);
    step(0, 0, 0, 1, 0, 32'h40, 0, 0);
    step(0, 1, 32'h102, 0, 1, 32'h13C, 32'h5555AAAA, 4'hf);
    drain();
    for (int g = 0; g < NL; g++) begin
      total++;
      if (aq[g].size() != eq[g].size()) begin
        bad++;
        $display("FAIL faults L%0d count got %0d want %0d",
                 g + 1, aq[g].size(), eq[g].size());
      end else for (int k = 0; k < eq[g].size(); k++) begin
        total++;
        if (aq[g][k] !== eq[g][k]) begin
          bad++;
          $display("FAIL faults L%0d #%0d got %h want %h",
                   g + 1, k, aq[g][k], eq[g][k]);
        end
      end
    end
    total++;
    if (aq[0].size() != 6) begin
      bad++;
      $display("FAIL faults_l1 count got %0d want 6", aq[0].size());
    end else begin
      total += 4;
      if (aq[0][0] !== rec_t'{32'(t0 + 1), 1'b1, 1'b1, 32'h0}) begin
        bad++;
        $display("FAIL fault_misalign got %h", aq[0][0]);
      end
      if (aq[0][1] !== rec_t'{32'(t0 + 2), 1'b1, 1'b1, 32'h0}) begin
        bad++;
        $display("FAIL fault_range got %h", aq[0][1]);
      end
      if (aq[0][2] !== rec_t'{32'(t0 + 3), 1'b1, 1'b1, 32'h0}) begin
        bad++;
        $display("FAIL fault_rw_both got %h", aq[0][2]);
      end
      if (aq[0][3] !== rec_t'{32'(t0 + 4), 1'b1, 1'b0, 32'hDEADBEAA}) begin
        bad++;
        $display("FAIL fault_mem_kept got %h want DEADBEAA", aq[0][3]);
      end
    end
  endtask

  task automatic test_collision();
    int t0;
    clear_logs();
    t0 = cyc;
    step(0, 1, 32'h10, 0, 1, 32'h10, 32'h12345678, 4'hf);
    step(0, 0, 0, 1, 0, 32'h10, 0, 0);
    drain();
    for (int g = 0; g < NL; g++) begin
      total++;
      if (aq[g].size() != eq[g].size()) begin
        bad++;
        $display("FAIL collision L%0d count got %0d want %0d",
                 g + 1, aq[g].size(), eq[g].size());
      end else for (int k = 0; k < eq[g].size(); k++) begin
        total++;
        if (aq[g][k] !== eq[g][k]) begin
          bad++;
          $display("FAIL collision L%0d #%0d got %h want %h",
                   g + 1, k, aq[g][k], eq[g][k]);
        end
      end
    end
    total++;
    if (aq[0].size() != 3) begin
      bad++;
      $display("FAIL collision_l1 count got %0d want 3", aq[0].size());
    end else begin
      total += 2;
      if (aq[0][0] !== rec_t'{32'(t0 + 1), 1'b0, 1'b0, 32'h002000b3}) begin
        bad++;
        $display("FAIL collision_fetch_old got %h want 002000b3", aq[0][0]);
      end
      if (aq[0][2] !== rec_t'{32'(t0 + 2), 1'b1, 1'b0, 32'h12345678}) begin
        bad++;
        $display("FAIL collision_load_new got %h want 12345678", aq[0][2]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int t0;
    clear_logs();
    t0 = cyc;
    step(0, 0, 0, 1, 0, 32'h40, 0, 0);
    idle();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int g = 0; g < NL; g++) begin
      total++;
      if ({mdat[g], mrv[g], mflt[g]} !== 34'd0) begin
        bad++;
        $display("FAIL midreset_zero L%0d got %h %b%b want 0",
                 g + 1, mdat[g], mrv[g], mflt[g]);
      end
    end
    idle();
    step(0, 0, 0, 1, 0, 32'h40, 0, 0);
    drain();
    for (int g = 0; g < NL; g++) begin
      total++;
      if (aq[g].size() != eq[g].size()) begin
        bad++;
        $display("FAIL midreset L%0d count got %0d want %0d",
                 g + 1, aq[g].size(), eq[g].size());
      end else for (int k = 0; k < eq[g].size(); k++) begin
        total++;
        if (aq[g][k] !== eq[g][k]) begin
          bad++;
          $display("FAIL midreset L%0d #%0d got %h want %h",
                   g + 1, k, aq[g][k], eq[g][k]);
        end
      end
    end
    total++;
    if (aq[3].size() != 1) begin
      bad++;
      $display("FAIL midreset_l4 count got %0d want 1", aq[3].size());
    end else begin
      total++;
      if (aq[3][0] !== rec_t'{32'(t0 + 8), 1'b1, 1'b0, 32'hDEADBEAA}) begin
        bad++;
        $display("FAIL midreset_l4_kept got %h want DEADBEAA", aq[3][0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    clear_logs();
    t0 = cyc;
    for (int k = 0; k < 16; k++)
      step(0, 0, 0, 1, 0, BASE + 32'(k * 4), 0, 0);
    drain();
    for (int g = 0; g < NL; g++) begin
      total++;
      if (aq[g].size() != eq[g].size()) begin
        bad++;
        $display("FAIL b2b L%0d count got %0d want %0d",
                 g + 1, aq[g].size(), eq[g].size());
      end else for (int k = 0; k < eq[g].size(); k++) begin
        total++;
        if (aq[g][k] !== eq[g][k]) begin
          bad++;
          $display("FAIL b2b L%0d #%0d got %h want %h",
                   g + 1, k, aq[g][k], eq[g][k]);
        end
      end
    end
    total++;
    if (aq[1].size() != 16) begin
      bad++;
      $display("FAIL b2b_l2 count got %0d want 16", aq[1].size());
    end else for (int k = 0; k < 16; k++) begin
      total++;
      if (aq[1][k] !== rec_t'{32'(t0 + k + 2), 1'b1, 1'b0, mm[k]}) begin
        bad++;
        $display("FAIL b2b_l2 #%0d got %h want cyc %0d data %h",
                 k, aq[1][k], t0 + k + 2, mm[k]);
      end
    end
    total++;
    if ({mdat[1], mrv[1], mflt[1]} !== {mm[15], 2'b00}) begin
      bad++;
      $display("FAIL b2b_hold got %h %b%b want %h 00",
               mdat[1], mrv[1], mflt[1], mm[15]);
    end
  endtask

  task automatic test_random();
    logic        r, f_v, m_r, m_w;
    logic [31:0] f_a, m_a;
    clear_logs();
    for (int n = 0; n < 400; n++) begin
      r   = ($urandom_range(0, 39) == 0);
      f_v = ($urandom_range(0, 9) < 7);
      m_r = ($urandom_range(0, 9) < 4);
      m_w = ($urandom_range(0, 9) < 4);
      f_a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
      m_a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4);
      case ($urandom_range(0, 7))
        0: m_a = m_a | 32'($urandom_range(1, 3));
        1: m_a = BASE + DEPTH * 4 + 32'($urandom_range(0, 15) * 4);
        2: f_a = f_a | 32'($urandom_range(1, 3));
        3: f_a = 32'hFFFF_FFFC;
        default: ;
      endcase
      step(r, f_v, f_a, m_r, m_w, m_a, $urandom, 4'($urandom));
    end
    drain();
    for (int g = 0; g < NL; g++) begin
      total++;
      if (aq[g].size() != eq[g].size()) begin
        bad++;
        $display("FAIL random L%0d count got %0d want %0d",
                 g + 1, aq[g].size(), eq[g].size());
      end else for (int k = 0; k < eq[g].size(); k++) begin
        total++;
        if (aq[g][k] !== eq[g][k]) begin
          bad++;
          $display("FAIL random L%0d #%0d got %h want %h",
                   g + 1, k, aq[g][k], eq[g][k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_fetch_seq();
    test_store_load();
    test_faults();
    test_collision();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
